conv_ctrl: RTL and testbench

CONV_CTRL -- requirements
Module: conv_ctrl

---
 rtl/conv_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_conv_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl.sv
// conv_ctrl: sequencer for one ifmap-by-filter convolution job.
// Loads the filter into the PE rows, streams the ifmap column by column,
// waits out the PE pipeline, then drains one ofmap column per streamed
// column once the filter window is fully covered.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   start                 job request, sampled only while idle
//   busy, done            job in progress / one-cycle end-of-job pulse
//   fil_rd_en/addr        filter RAM read, addr = row*FIL_S+col
//   fil_vld/row/col       filter word valid + tags, read strobe delayed 1
//   di_rd_en/addr         ifmap RAM read, addr = row*DI_W+col
//   pe_en/row/col         ifmap word valid + tags, read strobe delayed 1
//   pe_clr                clear PE partial sums
//   do_wr_valid/ready     ofmap write handshake
//   do_wr_addr            ofmap address, y*DO_W+x
module conv_ctrl #(
  parameter int unsigned INWIDTH  = 16,
  parameter int unsigned DI_W     = 7,
  parameter int unsigned FIL_S    = 3,
  parameter int unsigned DO_W     = 5,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            fil_rd_en,
  output logic [$clog2(FIL_S*FIL_S)-1:0]  fil_rd_addr,
  output logic                            fil_vld,
  output logic [$clog2(FIL_S)-1:0]        fil_row,
  output logic [$clog2(FIL_S)-1:0]        fil_col,
  output logic                            di_rd_en,
  output logic [$clog2(DI_W*DI_W)-1:0]    di_rd_addr,
  output logic                            pe_en,
  output logic [$clog2(DI_W)-1:0]         pe_row,
  output logic [$clog2(DI_W)-1:0]         pe_col,
  output logic                            pe_clr,
  output logic                            do_wr_valid,
  input  logic                            do_wr_ready,
  output logic [$clog2(DO_W*DO_W)-1:0]    do_wr_addr
);

  localparam int unsigned FA_W = $clog2(FIL_S*FIL_S);
  localparam int unsigned FR_W = $clog2(FIL_S);
  localparam int unsigned DA_W = $clog2(DI_W*DI_W);
  localparam int unsigned DR_W = $clog2(DI_W);
  localparam int unsigned OA_W = $clog2(DO_W*DO_W);
  localparam int unsigned OY_W = $clog2(DO_W);
  localparam int unsigned WC_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  // Reject parameter sets the sequencing cannot honour.
  if (INWIDTH < 1 || PIPE_LAT < 1 || DO_W != DI_W - FIL_S + 1) begin : g_bad_param
    $error("conv_ctrl: inconsistent parameters");
  end

  typedef enum logic [2:0] {IDLE, FIL, READ, WAIT, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [FR_W-1:0]   frow_q, frow_d, fcol_q, fcol_d;
  logic [DR_W-1:0]   r_q, r_d, c_q, c_d;
  logic [OY_W-1:0]   y_q, y_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic              pe_clr_fil_q;

  logic              busy_d, done_d, fil_en_d, di_en_d, do_vld_d, clr_fil_d;
  logic [FA_W-1:0]   fil_addr_d;
  logic [DA_W-1:0]   di_addr_d;
  logic [OA_W-1:0]   do_addr_d;

  // Next state / counters, then the outputs the next cycle must show.
  always_comb begin
    state_d = state_q;
    frow_d  = frow_q;
    fcol_d  = fcol_q;
    r_d     = r_q;
    c_d     = c_q;
    y_d     = y_q;
    wc_d    = wc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FIL;
          frow_d  = '0;
          fcol_d  = '0;
        end
      end
      FIL: begin
        if (fcol_q == FR_W'(FIL_S - 1)) begin
          fcol_d = '0;
          if (frow_q == FR_W'(FIL_S - 1)) begin
            state_d = READ;
            r_d     = '0;
            c_d     = '0;
          end else begin
            frow_d = frow_q + FR_W'(1);
          end
        end else begin
          fcol_d = fcol_q + FR_W'(1);
        end
      end
      READ: begin
        if (r_q == DR_W'(DI_W - 1)) begin
          r_d = '0;
          // Output columns exist only once a full filter width has streamed.
          if (c_q >= DR_W'(FIL_S - 1)) begin
            state_d = WAIT;
            wc_d    = '0;
          end else begin
            c_d = c_q + DR_W'(1);
          end
        end else begin
          r_d = r_q + DR_W'(1);
        end
      end
      WAIT: begin
        if (wc_q == WC_W'(PIPE_LAT - 1)) begin
          state_d = DRAIN;
          y_d     = '0;
        end else begin
          wc_d = wc_q + WC_W'(1);
        end
      end
      DRAIN: begin
        if (do_wr_ready) begin
          if (y_q == OY_W'(DO_W - 1)) begin
            if (c_q == DR_W'(DI_W - 1)) begin
              state_d = DONE;
            end else begin
              state_d = READ;
              r_d     = '0;
              c_d     = c_q + DR_W'(1);
            end
          end else begin
            y_d = y_q + OY_W'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    fil_en_d   = (state_d == FIL);
    di_en_d    = (state_d == READ);
    do_vld_d   = (state_d == DRAIN);
    clr_fil_d  = fil_en_d && (frow_d == FR_W'(FIL_S - 1)) && (fcol_d == FR_W'(FIL_S - 1));
    fil_addr_d = fil_en_d ? FA_W'(frow_d) * FA_W'(FIL_S) + FA_W'(fcol_d) : '0;
    di_addr_d  = di_en_d ? DA_W'(r_d) * DA_W'(DI_W) + DA_W'(c_d) : '0;
    do_addr_d  = do_vld_d ? OA_W'(y_d) * OA_W'(DO_W) + OA_W'(c_d) - OA_W'(FIL_S - 1) : '0;
  end

  // State, counters, registered strobes and the 1-cycle-late RAM tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      frow_q       <= '0;
      fcol_q       <= '0;
      r_q          <= '0;
      c_q          <= '0;
      y_q          <= '0;
      wc_q         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fil_rd_en    <= 1'b0;
      fil_rd_addr  <= '0;
      di_rd_en     <= 1'b0;
      di_rd_addr   <= '0;
      do_wr_valid  <= 1'b0;
      do_wr_addr   <= '0;
      pe_clr_fil_q <= 1'b0;
      fil_vld      <= 1'b0;
      fil_row      <= '0;
      fil_col      <= '0;
      pe_en        <= 1'b0;
      pe_row       <= '0;
      pe_col       <= '0;
    end else begin
      state_q      <= state_d;
      frow_q       <= frow_d;
      fcol_q       <= fcol_d;
      r_q          <= r_d;
      c_q          <= c_d;
      y_q          <= y_d;
      wc_q         <= wc_d;
      busy         <= busy_d;
      done         <= done_d;
      fil_rd_en    <= fil_en_d;
      fil_rd_addr  <= fil_addr_d;
      di_rd_en     <= di_en_d;
      di_rd_addr   <= di_addr_d;
      do_wr_valid  <= do_vld_d;
      do_wr_addr   <= do_addr_d;
      pe_clr_fil_q <= clr_fil_d;
      // Counters still hold the indices of the read currently on the bus.
      fil_vld      <= fil_rd_en;
      fil_row      <= fil_rd_en ? frow_q : '0;
      fil_col      <= fil_rd_en ? fcol_q : '0;
      pe_en        <= di_rd_en;
      pe_row       <= di_rd_en ? r_q : '0;
      pe_col       <= di_rd_en ? c_q : '0;
    end
  end

  // The drain-side clear must coincide with the accepted last write of a
  // column, so it follows do_wr_ready in the same cycle.
  assign pe_clr = pe_clr_fil_q
                | (do_wr_valid && do_wr_ready && (y_q == OY_W'(DO_W - 1)));

endmodule

// File: tb/tb_conv_ctrl.sv
module tb_conv_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done;
  logic       fil_rd_en;
  logic [3:0] fil_rd_addr;
  logic       fil_vld;
  logic [1:0] fil_row, fil_col;
  logic       di_rd_en;
  logic [5:0] di_rd_addr;
  logic       pe_en;
  logic [2:0] pe_row, pe_col;
  logic       pe_clr;
  logic       do_wr_valid;
  logic       do_wr_ready;
  logic [4:0] do_wr_addr;

  conv_ctrl #(.INWIDTH(16), .DI_W(7), .FIL_S(3), .DO_W(5), .PIPE_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fil_rd_en(fil_rd_en), .fil_rd_addr(fil_rd_addr), .fil_vld(fil_vld),
    .fil_row(fil_row), .fil_col(fil_col), .di_rd_en(di_rd_en),
    .di_rd_addr(di_rd_addr), .pe_en(pe_en), .pe_row(pe_row), .pe_col(pe_col),
    .pe_clr(pe_clr), .do_wr_valid(do_wr_valid), .do_wr_ready(do_wr_ready),
    .do_wr_addr(do_wr_addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endfunction

  // Job model: the job is an ordered list of beats; each beat lasts one cycle,
  // except drain beats, which last until do_wr_ready accepts them.
  localparam int K_FIL = 0, K_RD = 1, K_WT = 2, K_DR = 3, K_DN = 4;
  typedef struct { int kind; int addr; int row; int col; bit clr; } ent_t;
  ent_t q[$];
  bit pf_v = 0, pd_v = 0;
  int pf_r = 0, pf_c = 0, pd_r = 0, pd_c = 0;

  function automatic void push_beat(int kind, int addr, int row, int col, bit clr);
    ent_t e;
    e.kind = kind; e.addr = addr; e.row = row; e.col = col; e.clr = clr;
    q.push_back(e);
  endfunction

  function automatic void push_job();
    for (int k = 0; k < 9; k++) push_beat(K_FIL, k, k / 3, k % 3, k == 8);
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 7; r++) push_beat(K_RD, r * 7 + c, r, c, 1'b0);
      if (c >= 2) begin
        for (int w = 0; w < 2; w++) push_beat(K_WT, 0, 0, 0, 1'b0);
        for (int y = 0; y < 5; y++) push_beat(K_DR, y * 5 + (c - 2), 0, 0, y == 4);
      end
    end
    push_beat(K_DN, 0, 0, 0, 1'b0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      pf_v <= 1'b0;
      pd_v <= 1'b0;
    end else if (q.size() != 0) begin
      pf_v <= (q[0].kind == K_FIL);
      pf_r <= q[0].row;
      pf_c <= q[0].col;
      pd_v <= (q[0].kind == K_RD);
      pd_r <= q[0].row;
      pd_c <= q[0].col;
      if (q[0].kind != K_DR || do_wr_ready) void'(q.pop_front());
    end else begin
      pf_v <= 1'b0;
      pd_v <= 1'b0;
      if (start) push_job();
    end
  end

  // Per-cycle comparison of every output against the model.
  ent_t h;
  always @(negedge clk) begin
    if (q.size() != 0) h = q[0];
    else begin h.kind = -1; h.addr = 0; h.row = 0; h.col = 0; h.clr = 1'b0; end
    chk("busy", int'(busy), int'(q.size() != 0));
    chk("done", int'(done), int'(h.kind == K_DN));
    chk("fil_rd_en", int'(fil_rd_en), int'(h.kind == K_FIL));
    if (h.kind == K_FIL) chk("fil_rd_addr", int'(fil_rd_addr), h.addr);
    chk("di_rd_en", int'(di_rd_en), int'(h.kind == K_RD));
    if (h.kind == K_RD) chk("di_rd_addr", int'(di_rd_addr), h.addr);
    chk("do_wr_valid", int'(do_wr_valid), int'(h.kind == K_DR));
    if (h.kind == K_DR) chk("do_wr_addr", int'(do_wr_addr), h.addr);
    chk("pe_clr", int'(pe_clr),
        int'((h.kind == K_FIL && h.clr) || (h.kind == K_DR && h.clr && do_wr_ready)));
    chk("fil_vld", int'(fil_vld), int'(pf_v));
    if (pf_v) begin
      chk("fil_row", int'(fil_row), pf_r);
      chk("fil_col", int'(fil_col), pf_c);
    end
    chk("pe_en", int'(pe_en), int'(pd_v));
    if (pd_v) begin
      chk("pe_row", int'(pe_row), pd_r);
      chk("pe_col", int'(pe_col), pd_c);
    end
  end

  // Event counters used by the scenario-level checks.
  int done_cnt = 0, fil_cnt = 0, clr_cnt = 0;
  int wr_hits[25];
  initial for (int i = 0; i < 25; i++) wr_hits[i] = 0;
  always @(negedge clk) begin
    done_cnt <= done_cnt + int'(done);
    fil_cnt  <= fil_cnt + int'(fil_rd_en);
    clr_cnt  <= clr_cnt + int'(pe_clr);
    if (do_wr_valid && do_wr_ready && do_wr_addr < 5'd25)
      wr_hits[do_wr_addr] <= wr_hits[do_wr_addr] + 1;
  end

  task automatic drive_at(int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic neg_at(int n);
    while (cyc < n) begin @(posedge clk); #1; end
    @(negedge clk);
  endtask

  task automatic begin_job(int t);
    drive_at(t); start = 1'b1;
    neg_at(t);   chk("idle_busy_before_job", int'(busy), 0);
    drive_at(t + 1); start = 1'b0;
  endtask

  task automatic nominal(int t);
    int d0;
    d0 = done_cnt;
    begin_job(t);
    neg_at(t + 1);  chk("nom_fil_addr0", int'(fil_rd_addr), 0);
                    chk("nom_busy_first", int'(busy), 1);
    neg_at(t + 9);  chk("nom_fil_addr8", int'(fil_rd_addr), 8);
    neg_at(t + 10); chk("nom_di_addr0", int'(di_rd_addr), 0);
    neg_at(t + 16); chk("nom_di_addr42", int'(di_rd_addr), 42);
    neg_at(t + 30); chk("nom_di_addr44", int'(di_rd_addr), 44);
    neg_at(t + 31); chk("nom_wait_no_strobe", int'(di_rd_en) + int'(do_wr_valid), 0);
    neg_at(t + 33); chk("nom_do_addr0", int'(do_wr_addr), 0);
    neg_at(t + 37); chk("nom_do_addr20", int'(do_wr_addr), 20);
    neg_at(t + 93); chk("nom_do_addr24", int'(do_wr_addr), 24);
    neg_at(t + 94); chk("nom_done", int'(done), 1);
                    chk("nom_busy_last", int'(busy), 1);
    neg_at(t + 95); chk("nom_idle_after", int'(busy) + int'(done), 0);
                    chk("nom_done_count", done_cnt - d0, 1);
  endtask

  int t, d0, f0, c0;
  int snap[25];

  initial begin
    rst = 1'b0; start = 1'b0; do_wr_ready = 1'b1;
    neg_at(1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_strobes", int'(fil_rd_en) + int'(di_rd_en) + int'(do_wr_valid), 0);
    chk("reset_delayed", int'(fil_vld) + int'(pe_en) + int'(pe_clr) + int'(done), 0);
    drive_at(3); rst = 1'b1;
    neg_at(4); chk("release_no_stale", int'(fil_vld) + int'(pe_en) + int'(busy), 0);

    // Nominal job.
    t = 5;
    nominal(t);

    // Backpressure on the first drain beat.
    t = t + 100;
    d0 = done_cnt;
    for (int i = 0; i < 25; i++) snap[i] = wr_hits[i];
    begin_job(t);
    drive_at(t + 33); do_wr_ready = 1'b0;
    neg_at(t + 33); chk("bp_valid_held", int'(do_wr_valid), 1);
    neg_at(t + 35); chk("bp_addr_held", int'(do_wr_addr), 0);
                    chk("bp_valid_still", int'(do_wr_valid), 1);
    drive_at(t + 36); do_wr_ready = 1'b1;
    neg_at(t + 37); chk("bp_addr5_late", int'(do_wr_addr), 5);
    neg_at(t + 96); chk("bp_no_early_done", int'(done), 0);
    neg_at(t + 97); chk("bp_done_late", int'(done), 1);
    neg_at(t + 98);
    chk("bp_done_count", done_cnt - d0, 1);
    for (int i = 0; i < 25; i++) chk("bp_write_once", wr_hits[i] - snap[i], 1);

    // Start pulses during a job are ignored.
    t = t + 105;
    d0 = done_cnt; f0 = fil_cnt;
    begin_job(t);
    drive_at(t + 20); start = 1'b1;
    drive_at(t + 21); start = 1'b0;
    drive_at(t + 50); start = 1'b1;
    drive_at(t + 51); start = 1'b0;
    neg_at(t + 94); chk("ign_done", int'(done), 1);
    neg_at(t + 100);
    chk("ign_busy_after", int'(busy), 0);
    chk("ign_done_count", done_cnt - d0, 1);
    chk("ign_fil_beats", fil_cnt - f0, 9);

    // Reset mid-job aborts without done, then a fresh job runs nominally.
    t = t + 105;
    d0 = done_cnt;
    begin_job(t);
    drive_at(t + 40); rst = 1'b0;
    neg_at(t + 40);
    chk("rst_outputs_zero", int'(busy) + int'(done) + int'(fil_rd_en) + int'(di_rd_en)
        + int'(do_wr_valid) + int'(pe_en) + int'(fil_vld) + int'(pe_clr)
        + int'(di_rd_addr) + int'(pe_row) + int'(pe_col), 0);
    drive_at(t + 42); rst = 1'b1;
    neg_at(t + 44);
    chk("rst_idle_after", int'(busy), 0);
    chk("rst_no_done", done_cnt - d0, 0);
    t = t + 46;
    nominal(t);

    // Back-to-back jobs with start held high.
    t = t + 100;
    d0 = done_cnt; c0 = clr_cnt;
    drive_at(t); start = 1'b1;
    neg_at(t + 94);  chk("b2b_done1", int'(done), 1);
    neg_at(t + 95);  chk("b2b_idle_gap", int'(busy) + int'(fil_rd_en), 0);
    neg_at(t + 96);  chk("b2b_fil2_start", int'(fil_rd_en), 1);
                     chk("b2b_fil2_addr", int'(fil_rd_addr), 0);
    drive_at(t + 100); start = 1'b0;
    neg_at(t + 189); chk("b2b_done2", int'(done), 1);
    neg_at(t + 191);
    chk("b2b_idle_end", int'(busy), 0);
    chk("b2b_done_count", done_cnt - d0, 2);
    chk("b2b_pe_clr_count", clr_cnt - c0, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1);
  end

endmodule
